enigma_stepper_engine: RTL and testbench

Clocked, parametrised rotor-position engine for the Enigma datapath. It holds NUM_ROTORS rotor positions and advances them one keystroke at a time, forward (encrypt stepping) or reverse (undo/backspace).
- Forward mode uses per-rotor notches and optional historical double-stepping.
- It replaces combinational, level-triggered stepping with a valid/ready handshake, a load path, a wrap flag and a step counter.
- It sits between keyboard/UART control and the rotor substitution datapath, which consumes pos_out.

---
 rtl/enigma_stepper_engine_if.sv | 29 ++
 rtl/enigma_stepper_engine.sv | 114 +++++++++++
 tb/tb_enigma_stepper_engine.sv | 155 +++++++++++++++
 3 files changed

// File: rtl/enigma_stepper_engine_if.sv
// Step/load handshake bundle between keyboard/UART control and the rotor stepper.
// The master drives requests; the slave (the engine) returns positions and status.
interface enigma_stepper_engine_if #(
  parameter int NUM_ROTORS = 3,
  parameter int W          = 5,
  parameter int CNT_W      = 16
);
  logic                    load;
  logic [NUM_ROTORS*W-1:0] load_pos;
  logic [NUM_ROTORS*W-1:0] notch_pos;
  logic                    step_valid;
  logic                    step_dir;
  logic                    step_ready;
  logic [NUM_ROTORS*W-1:0] pos_out;
  logic                    pos_done;
  logic                    wrap;
  logic                    load_err;
  logic [CNT_W-1:0]        step_cnt;

  modport master (
    output load, load_pos, notch_pos, step_valid, step_dir,
    input  step_ready, pos_out, pos_done, wrap, load_err, step_cnt
  );

  modport slave (
    input  load, load_pos, notch_pos, step_valid, step_dir,
    output step_ready, pos_out, pos_done, wrap, load_err, step_cnt
  );
endinterface

// File: rtl/enigma_stepper_engine.sv
// Rotor-position engine: advances NUM_ROTORS positions one keystroke at a time,
// forward with notches (optional double-step) or reverse as a plain odometer borrow.
module enigma_stepper_engine #(
  parameter int NUM_ROTORS  = 3,
  parameter int ALPHA       = 26,
  parameter int W           = 5,
  parameter int DOUBLE_STEP = 1,
  parameter int CNT_W       = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  enigma_stepper_engine_if.slave bus
);

  localparam logic [W:0] ALPHA_X = (W+1)'(ALPHA);
  localparam logic [W:0] ONE_X   = (W+1)'(1);

  typedef logic [NUM_ROTORS-1:0][W-1:0] pos_vec_t;

  pos_vec_t         pos_q, notch_q;
  pos_vec_t         pos_d, ld_pos_d, ld_notch_d;
  logic             pos_done_q, wrap_q, load_err_q;
  logic [CNT_W-1:0] step_cnt_q;
  logic             wrap_d, ld_err_d, accept;
  logic [NUM_ROTORS-1:0] adv;

  function automatic logic [W-1:0] inc_mod(input logic [W-1:0] p);
    logic [W:0] s;
    s = {1'b0, p} + ONE_X;
    if (s >= ALPHA_X) s = s - ALPHA_X;
    return s[W-1:0];
  endfunction

  function automatic logic [W-1:0] dec_mod(input logic [W-1:0] p);
    logic [W:0] s;
    s = {1'b0, p} + ALPHA_X - ONE_X;
    if (s >= ALPHA_X) s = s - ALPHA_X;
    return s[W-1:0];
  endfunction

  assign bus.step_ready = !rst && !bus.load;
  assign accept         = bus.step_valid && bus.step_ready;

  // All advance decisions look at pre-step positions, so every rotor moves together.
  always_comb begin
    // NOTE: every variable gets a default before any conditional write, so no latch is inferred.
    adv    = '0;
    pos_d  = pos_q;
    wrap_d = 1'b0;
    adv[0] = 1'b1;
    for (int i = 1; i < NUM_ROTORS; i++) begin
      if (bus.step_dir) begin
        adv[i] = (pos_q[i-1] == inc_mod(notch_q[i-1]));
      end else begin
        adv[i] = (pos_q[i-1] == notch_q[i-1]);
        if (DOUBLE_STEP != 0 && i <= NUM_ROTORS-2 && pos_q[i] == notch_q[i]) adv[i] = 1'b1;
      end
    end
    for (int i = 0; i < NUM_ROTORS; i++) begin
      if (adv[i]) pos_d[i] = bus.step_dir ? dec_mod(pos_q[i]) : inc_mod(pos_q[i]);
    end
    if (adv[NUM_ROTORS-1]) begin
      wrap_d = bus.step_dir ? (pos_q[NUM_ROTORS-1] == '0)
                            : ({1'b0, pos_q[NUM_ROTORS-1]} == ALPHA_X - ONE_X);
    end
  end

  // Out-of-range load fields are forced to 0 and flagged.
  always_comb begin
    ld_err_d   = 1'b0;
    ld_pos_d   = '0;
    ld_notch_d = '0;
    for (int i = 0; i < NUM_ROTORS; i++) begin
      if ({1'b0, bus.load_pos[i*W +: W]} >= ALPHA_X) ld_err_d = 1'b1;
      else ld_pos_d[i] = bus.load_pos[i*W +: W];
      if ({1'b0, bus.notch_pos[i*W +: W]} >= ALPHA_X) ld_err_d = 1'b1;
      else ld_notch_d[i] = bus.notch_pos[i*W +: W];
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      pos_q      <= '0;
      notch_q    <= '0;
      pos_done_q <= 1'b0;
      wrap_q     <= 1'b0;
      load_err_q <= 1'b0;
      step_cnt_q <= '0;
    end else if (bus.load) begin
      pos_q      <= ld_pos_d;
      notch_q    <= ld_notch_d;
      step_cnt_q <= '0;
      pos_done_q <= 1'b0;
      wrap_q     <= 1'b0;
      if (ld_err_d) load_err_q <= 1'b1;
    end else if (accept) begin
      pos_q      <= pos_d;
      step_cnt_q <= step_cnt_q + (bus.step_dir ? {CNT_W{1'b1}} : CNT_W'(1));
      pos_done_q <= 1'b1;
      wrap_q     <= wrap_d;
    end else begin
      pos_done_q <= 1'b0;
      wrap_q     <= 1'b0;
    end
  end

  assign bus.pos_out  = pos_q;
  assign bus.pos_done = pos_done_q;
  assign bus.wrap     = wrap_q;
  assign bus.load_err = load_err_q;
  assign bus.step_cnt = step_cnt_q;

endmodule

// File: tb/tb_enigma_stepper_engine.sv
// Directed bench: two engines (DOUBLE_STEP=1 and =0) driven in lockstep,
// checked against hand-computed rotor positions listed as (r2,r1,r0).
module tb_enigma_stepper_engine;

  logic clk = 1'b0;
  logic rst;
  int   n_cmp = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  enigma_stepper_engine_if #(.NUM_ROTORS(3), .W(5), .CNT_W(16)) bus1 ();
  enigma_stepper_engine_if #(.NUM_ROTORS(3), .W(5), .CNT_W(16)) bus0 ();

  enigma_stepper_engine #(.NUM_ROTORS(3), .ALPHA(26), .W(5), .DOUBLE_STEP(1), .CNT_W(16))
    dut_ds1 (.clk(clk), .rst(rst), .bus(bus1));
  enigma_stepper_engine #(.NUM_ROTORS(3), .ALPHA(26), .W(5), .DOUBLE_STEP(0), .CNT_W(16))
    dut_ds0 (.clk(clk), .rst(rst), .bus(bus0));

  function automatic logic [14:0] pk(input int r2, input int r1, input int r0);
    return {5'(r2), 5'(r1), 5'(r0)};
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic drive(input logic ld, input logic [14:0] lp, input logic [14:0] np,
                       input logic sv, input logic sd);
    bus1.load = ld; bus1.load_pos = lp; bus1.notch_pos = np; bus1.step_valid = sv; bus1.step_dir = sd;
    bus0.load = ld; bus0.load_pos = lp; bus0.notch_pos = np; bus0.step_valid = sv; bus0.step_dir = sd;
  endtask

  task automatic do_load(input logic [14:0] lp, input logic [14:0] np);
    drive(1'b1, lp, np, 1'b0, 1'b0);
    @(posedge clk); #1;
    drive(1'b0, '0, '0, 1'b0, 1'b0);
  endtask

  task automatic do_step(input logic dir);
    drive(1'b0, '0, '0, 1'b1, dir);
    @(posedge clk); #1;
    drive(1'b0, '0, '0, 1'b0, 1'b0);
  endtask

  logic [14:0] notch_def;

  initial begin
    notch_def = pk(16, 4, 21);
    rst = 1'b1;
    drive(1'b0, '0, '0, 1'b0, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    check("rst_pos",   32'(bus1.pos_out),  32'(pk(0, 0, 0)));
    check("rst_done",  32'(bus1.pos_done), 32'd0);
    check("rst_wrap",  32'(bus1.wrap),     32'd0);
    check("rst_err",   32'(bus1.load_err), 32'd0);
    check("rst_cnt",   32'(bus1.step_cnt), 32'd0);
    check("rst_ready", 32'(bus1.step_ready), 32'd0);
    rst = 1'b0;
    #1;
    check("ready_idle", 32'(bus1.step_ready), 32'd1);

    // Double-step anomaly: DS=1 middle rotor moves twice, DS=0 does not.
    do_load(pk(0, 3, 20), notch_def);
    check("ds_load_pos",  32'(bus1.pos_out),  32'(pk(0, 3, 20)));
    check("ds_load_done", 32'(bus1.pos_done), 32'd0);
    do_step(1'b0);
    check("ds_s1_pos",  32'(bus1.pos_out),  32'(pk(0, 3, 21)));
    check("ds_s1_done", 32'(bus1.pos_done), 32'd1);
    check("ds_s1_wrap", 32'(bus1.wrap),     32'd0);
    do_step(1'b0);
    check("ds_s2_pos",  32'(bus1.pos_out),  32'(pk(0, 4, 22)));
    check("ds_s2_done", 32'(bus1.pos_done), 32'd1);
    do_step(1'b0);
    check("ds_s3_pos",  32'(bus1.pos_out),  32'(pk(1, 5, 23)));
    check("ds_s3_done", 32'(bus1.pos_done), 32'd1);
    check("ds_s3_cnt",  32'(bus1.step_cnt), 32'd3);
    check("nods_s3_pos", 32'(bus0.pos_out), 32'(pk(1, 4, 23)));
    @(posedge clk); #1;
    check("ds_idle_done", 32'(bus1.pos_done), 32'd0);

    // Reverse then forward restores the start position.
    do_load(pk(0, 0, 22), notch_def);
    do_step(1'b1);
    check("inv_rev_pos", 32'(bus0.pos_out),  32'(pk(0, 25, 21)));
    check("inv_rev_cnt", 32'(bus0.step_cnt), 32'hFFFF);
    check("inv_rev_pos1", 32'(bus1.pos_out), 32'(pk(0, 25, 21)));
    do_step(1'b0);
    check("inv_fwd_pos", 32'(bus0.pos_out),  32'(pk(0, 0, 22)));
    check("inv_fwd_cnt", 32'(bus0.step_cnt), 32'd0);

    // Wrap of the slowest rotor in both directions.
    do_load(pk(25, 4, 21), notch_def);
    do_step(1'b0);
    check("wrap_fwd_pos",  32'(bus1.pos_out),  32'(pk(0, 5, 22)));
    check("wrap_fwd_flag", 32'(bus1.wrap),     32'd1);
    check("wrap_fwd_done", 32'(bus1.pos_done), 32'd1);
    do_step(1'b1);
    check("wrap_rev_pos",  32'(bus1.pos_out),  32'(pk(25, 4, 21)));
    check("wrap_rev_flag", 32'(bus1.wrap),     32'd1);
    check("wrap_rev_cnt",  32'(bus1.step_cnt), 32'd0);
    do_load(pk(0, 0, 0), notch_def);
    do_step(1'b1);
    check("rev_nocarry_pos",  32'(bus1.pos_out), 32'(pk(0, 0, 25)));
    check("rev_nocarry_wrap", 32'(bus1.wrap),    32'd0);
    do_load(pk(0, 0, 0), pk(25, 25, 25));
    do_step(1'b1);
    check("rev_all_pos",  32'(bus1.pos_out), 32'(pk(25, 25, 25)));
    check("rev_all_wrap", 32'(bus1.wrap),    32'd1);

    // Out-of-range load field, sticky error, and load priority over step.
    do_load(pk(0, 30, 5), notch_def);
    check("lerr_pos", 32'(bus1.pos_out),  32'(pk(0, 0, 5)));
    check("lerr_flag", 32'(bus1.load_err), 32'd1);
    do_load(pk(1, 2, 3), notch_def);
    check("lerr_sticky", 32'(bus1.load_err), 32'd1);
    drive(1'b1, pk(2, 2, 2), notch_def, 1'b1, 1'b0);
    #1;
    check("prio_ready", 32'(bus1.step_ready), 32'd0);
    @(posedge clk); #1;
    drive(1'b0, '0, '0, 1'b0, 1'b0);
    check("prio_pos",  32'(bus1.pos_out),  32'(pk(2, 2, 2)));
    check("prio_done", 32'(bus1.pos_done), 32'd0);
    check("prio_cnt",  32'(bus1.step_cnt), 32'd0);

    // Reset lands on the third of a back-to-back burst.
    do_load(pk(0, 0, 0), notch_def);
    drive(1'b0, '0, '0, 1'b1, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    check("burst_pos", 32'(bus1.pos_out),  32'(pk(0, 0, 2)));
    check("burst_cnt", 32'(bus1.step_cnt), 32'd2);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    drive(1'b0, '0, '0, 1'b0, 1'b0);
    check("mid_rst_pos",  32'(bus1.pos_out),  32'(pk(0, 0, 0)));
    check("mid_rst_done", 32'(bus1.pos_done), 32'd0);
    check("mid_rst_cnt",  32'(bus1.step_cnt), 32'd0);
    check("mid_rst_err",  32'(bus1.load_err), 32'd0);
    // Notches are zero after reset, so every rotor carries on the next step.
    do_step(1'b0);
    check("post_rst_pos1", 32'(bus1.pos_out), 32'(pk(1, 1, 1)));
    check("post_rst_pos0", 32'(bus0.pos_out), 32'(pk(1, 1, 1)));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
